// File: rtl/mips_main.sv
// Five-stage MIPS integer core (IF/ID/EX/MEM/WB). There is no forwarding and no interlock:
// software must pad dependent instructions with NOPs.
module mips_main (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  instruction_mem [0:255],
  output logic [31:0] next_instruction,
  output logic [31:0] alu_result
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] F_SLL    = 6'h00;
  localparam logic [5:0] F_SRL    = 6'h02;
  localparam logic [5:0] F_ADD    = 6'h20;
  localparam logic [5:0] F_SUB    = 6'h22;
  localparam logic [5:0] F_AND    = 6'h24;
  localparam logic [5:0] F_OR     = 6'h25;

  logic [31:0] r_pc;
  logic [31:0] r_ifid_instr;
  logic [31:0] r_idex_instr, r_idex_rs_val, r_idex_rt_val;
  logic [31:0] r_exmem_instr, r_exmem_alu, r_exmem_rt_val;
  logic [31:0] r_memwb_data;
  logic [4:0]  r_memwb_dest;
  logic        r_memwb_we;
  logic [31:0] r_regs [0:31];
  logic [31:0] r_dmem [0:255];

  logic [7:0]  w_b0, w_b1, w_b2, w_b3;
  logic [4:0]  w_id_rs, w_id_rt;
  logic [31:0] w_id_rs_val, w_id_rt_val;
  logic [31:0] w_ex_imm, w_ex_alu;
  logic [5:0]  w_mem_op, w_mem_funct;
  logic [31:0] w_mem_word, w_mem_data;
  logic [4:0]  w_mem_dest;
  logic        w_mem_we, w_mem_store;
  logic        w_unused_bits;

  // Fetch: byte address wraps inside the 256-byte instruction memory.
  assign w_b0 = r_pc[7:0];
  assign w_b1 = w_b0 + 8'd1;
  assign w_b2 = w_b0 + 8'd2;
  assign w_b3 = w_b0 + 8'd3;
  assign next_instruction = {instruction_mem[w_b3], instruction_mem[w_b2],
                             instruction_mem[w_b1], instruction_mem[w_b0]};

  assign w_id_rs     = r_ifid_instr[25:21];
  assign w_id_rt     = r_ifid_instr[20:16];
  assign w_id_rs_val = (w_id_rs == 5'd0) ? '0 : r_regs[w_id_rs];
  assign w_id_rt_val = (w_id_rt == 5'd0) ? '0 : r_regs[w_id_rt];

  always_comb begin
    w_ex_imm = {{16{r_idex_instr[15]}}, r_idex_instr[15:0]};
    w_ex_alu = '0;
    case (r_idex_instr[31:26])
      OP_RTYPE: begin
        case (r_idex_instr[5:0])
          F_ADD:   w_ex_alu = r_idex_rs_val + r_idex_rt_val;
          F_SUB:   w_ex_alu = r_idex_rs_val - r_idex_rt_val;
          F_AND:   w_ex_alu = r_idex_rs_val & r_idex_rt_val;
          F_OR:    w_ex_alu = r_idex_rs_val | r_idex_rt_val;
          F_SLL:   w_ex_alu = r_idex_rt_val << r_idex_instr[10:6];
          F_SRL:   w_ex_alu = r_idex_rt_val >> r_idex_instr[10:6];
          default: w_ex_alu = '0;
        endcase
      end
      OP_ADDI, OP_LW, OP_LH, OP_LHU, OP_SW: w_ex_alu = r_idex_rs_val + w_ex_imm;
      default: w_ex_alu = '0;
    endcase
  end

  // The effective address is used directly as a word index, not a byte address.
  assign w_mem_op    = r_exmem_instr[31:26];
  assign w_mem_funct = r_exmem_instr[5:0];
  assign w_mem_word  = r_dmem[r_exmem_alu[7:0]];
  assign w_mem_store = (w_mem_op == OP_SW);

  always_comb begin
    w_mem_data = r_exmem_alu;
    w_mem_dest = '0;
    w_mem_we   = 1'b0;
    case (w_mem_op)
      OP_RTYPE: begin
        case (w_mem_funct)
          F_ADD, F_SUB, F_AND, F_OR, F_SLL, F_SRL: begin
            w_mem_we   = 1'b1;
            w_mem_dest = r_exmem_instr[15:11];
          end
          default: w_mem_we = 1'b0;
        endcase
      end
      OP_ADDI: begin
        w_mem_we   = 1'b1;
        w_mem_dest = r_exmem_instr[20:16];
      end
      OP_LW: begin
        w_mem_we   = 1'b1;
        w_mem_dest = r_exmem_instr[20:16];
        w_mem_data = w_mem_word;
      end
      OP_LH: begin
        w_mem_we   = 1'b1;
        w_mem_dest = r_exmem_instr[20:16];
        w_mem_data = {{16{w_mem_word[15]}}, w_mem_word[15:0]};
      end
      OP_LHU: begin
        w_mem_we   = 1'b1;
        w_mem_dest = r_exmem_instr[20:16];
        w_mem_data = {16'h0000, w_mem_word[15:0]};
      end
      default: w_mem_we = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc           <= '0;
      r_ifid_instr   <= '0;
      r_idex_instr   <= '0;
      r_idex_rs_val  <= '0;
      r_idex_rt_val  <= '0;
      r_exmem_instr  <= '0;
      r_exmem_alu    <= '0;
      r_exmem_rt_val <= '0;
      r_memwb_data   <= '0;
      r_memwb_dest   <= '0;
      r_memwb_we     <= 1'b0;
    end else begin
      r_pc           <= r_pc + 32'd4;
      r_ifid_instr   <= next_instruction;
      r_idex_instr   <= r_ifid_instr;
      r_idex_rs_val  <= w_id_rs_val;
      r_idex_rt_val  <= w_id_rt_val;
      r_exmem_instr  <= r_idex_instr;
      r_exmem_alu    <= w_ex_alu;
      r_exmem_rt_val <= r_idex_rt_val;
      r_memwb_data   <= w_mem_data;
      r_memwb_dest   <= w_mem_dest;
      r_memwb_we     <= w_mem_we;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < 32; i++) r_regs[i] <= '0;
    end else if (r_memwb_we && (r_memwb_dest != 5'd0)) begin
      r_regs[r_memwb_dest] <= r_memwb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < 256; i++) r_dmem[i] <= '0;
    end else if (w_mem_store) begin
      r_dmem[r_exmem_alu[7:0]] <= r_exmem_rt_val;
    end
  end

  assign alu_result    = r_exmem_alu;
  assign w_unused_bits = ^{r_pc[31:8], r_exmem_instr[25:21], r_exmem_instr[10:6]};

endmodule

// File: tb/tb_mips_main.sv
// Bench for mips_main: directed programs plus random programs checked against an
// instruction-level model where a result becomes readable four slots after its producer.
module tb_mips_main;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  imem [0:255];
  logic [31:0] next_instruction;
  logic [31:0] alu_result;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_dir [0:63];
  logic [31:0] m_alu   [0:511];

  always #5 clk = ~clk;

  mips_main dut (
    .clk              (clk),
    .reset            (reset),
    .instruction_mem  (imem),
    .next_instruction (next_instruction),
    .alu_result       (alu_result)
  );

  function automatic logic [31:0] r_ins(input int rs, input int rt, input int rd,
                                        input int sh, input int fn);
    return {6'h00, rs[4:0], rt[4:0], rd[4:0], sh[4:0], fn[5:0]};
  endfunction

  function automatic logic [31:0] i_ins(input int op, input int rs, input int rt, input int imm);
    return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
  endfunction

  function automatic logic [31:0] get_word(input int slot);
    int base;
    base = (slot * 4) % 256;
    return {imem[base+3], imem[base+2], imem[base+1], imem[base]};
  endfunction

  task automatic put_word(input int slot, input logic [31:0] w);
    int base;
    base = (slot * 4) % 256;
    for (int b = 0; b < 4; b++) imem[base+b] = w[8*b +: 8];
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = 8'h00;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic logic [31:0] rand_ins();
    int kind, rs, rt, rd, sh, imm;
    int fn [6] = '{'h20, 'h22, 'h24, 'h25, 'h00, 'h02};
    kind = $urandom_range(0, 11);
    rs   = $urandom_range(0, 7);
    rt   = $urandom_range(0, 7);
    rd   = $urandom_range(0, 7);
    sh   = $urandom_range(0, 31);
    imm  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 65535) : $urandom_range(0, 7);
    case (kind)
      0, 1, 2, 3, 4, 5: return r_ins(rs, rt, rd, sh, fn[kind]);
      6:  return i_ins('h08, rs, rt, imm);
      7:  return i_ins('h23, rs, rt, imm);
      8:  return i_ins('h21, rs, rt, imm);
      9:  return i_ins('h25, rs, rt, imm);
      10: return i_ins('h2b, rs, rt, imm);
      default: return 32'h0;
    endcase
  endfunction

  // Sequential ISA execution; a register write from slot j is seen by slots >= j+4,
  // memory effects are seen by every later slot.
  task automatic model_run(input int n);
    logic [31:0] regs [32];
    logic [31:0] dm   [256];
    logic        pw   [512];
    logic [4:0]  pd   [512];
    logic [31:0] pv   [512];
    logic [31:0] ins, a, b, se, ea, w, alu;
    int op, fn, rs, rt, rd;
    for (int i = 0; i < 32; i++) regs[i] = 0;
    for (int i = 0; i < 256; i++) dm[i] = 0;
    for (int k = 0; k < n; k++) begin
      if (k >= 4 && pw[k-4] && pd[k-4] != 0) regs[pd[k-4]] = pv[k-4];
      ins = get_word(k % 64);
      op = int'(ins[31:26]); fn = int'(ins[5:0]);
      rs = int'(ins[25:21]); rt = int'(ins[20:16]); rd = int'(ins[15:11]);
      a  = regs[rs]; b = regs[rt];
      se = {{16{ins[15]}}, ins[15:0]};
      ea = a + se;
      w  = dm[ea[7:0]];
      pw[k] = 1'b0; pd[k] = 0; pv[k] = 0; alu = 0;
      if (op == 'h00) begin
        pw[k] = 1'b1; pd[k] = rd[4:0];
        case (fn)
          'h20: alu = a + b;
          'h22: alu = a - b;
          'h24: alu = a & b;
          'h25: alu = a | b;
          'h00: alu = b << ins[10:6];
          'h02: alu = b >> ins[10:6];
          default: pw[k] = 1'b0;
        endcase
        pv[k] = alu;
      end else if (op == 'h08) begin
        alu = ea; pw[k] = 1'b1; pd[k] = rt[4:0]; pv[k] = ea;
      end else if (op == 'h23 || op == 'h21 || op == 'h25) begin
        alu = ea; pw[k] = 1'b1; pd[k] = rt[4:0];
        if (op == 'h23)      pv[k] = w;
        else if (op == 'h21) pv[k] = {{16{w[15]}}, w[15:0]};
        else                 pv[k] = {16'h0000, w[15:0]};
      end else if (op == 'h2b) begin
        alu = ea; dm[ea[7:0]] = b;
      end
      m_alu[k] = alu;
    end
  endtask

  task automatic test_reset();
    logic [31:0] exp_w;
    reset = 1'b1;
    for (int i = 0; i < 256; i++) imem[i] = 8'($urandom_range(0, 255));
    repeat (3) @(negedge clk);
    checks++;
    if (alu_result !== 32'h0) begin
      errors++;
      $display("FAIL reset_alu got %h expected %h", alu_result, 32'h0);
    end
    exp_w = get_word(0);
    checks++;
    if (next_instruction !== exp_w) begin
      errors++;
      $display("FAIL reset_fetch got %h expected %h", next_instruction, exp_w);
    end
    imem[1] = imem[1] ^ 8'h5a;
    imem[3] = imem[3] ^ 8'hc3;
    #1;
    exp_w = get_word(0);
    checks++;
    if (next_instruction !== exp_w) begin
      errors++;
      $display("FAIL comb_fetch got %h expected %h", next_instruction, exp_w);
    end
  endtask

  task automatic emit(input int slot, input logic [31:0] ins, input logic [31:0] e);
    put_word(slot, ins);
    exp_dir[slot] = e;
  endtask

  task automatic test_directed();
    logic [31:0] e;
    clear_imem();
    for (int i = 0; i < 64; i++) exp_dir[i] = 32'h0;
    emit(0,  i_ins('h08, 0, 10, 10),       32'd10);
    emit(1,  i_ins('h08, 0, 12, 11),       32'd11);
    emit(5,  r_ins(12, 10, 11, 0, 'h20),   32'd21);
    emit(6,  r_ins(12, 10, 13, 0, 'h22),   32'd1);
    emit(7,  r_ins(10, 12, 14, 0, 'h24),   32'd10);
    emit(8,  r_ins(12, 10, 15, 0, 'h25),   32'd11);
    emit(9,  i_ins('h2b, 10, 11, 0),       32'd10);
    emit(13, i_ins('h23, 10, 16, 0),       32'd10);
    emit(14, i_ins('h08, 0, 19, 'h7fff),   32'h7fff);
    emit(18, i_ins('h08, 19, 19, 'h6000),  32'hdfff);
    emit(22, i_ins('h08, 19, 19, 'h6000),  32'h13fff);
    emit(26, i_ins('h08, 19, 19, 'h6000),  32'h19fff);
    emit(30, i_ins('h08, 19, 19, 'h6000),  32'h1ffff);
    emit(34, i_ins('h2b, 10, 19, 0),       32'd10);
    emit(38, i_ins('h21, 10, 17, 0),       32'd10);
    emit(39, i_ins('h25, 10, 18, 0),       32'd10);
    emit(43, r_ins(0, 18, 20, 2, 'h02),    32'h3fff);
    emit(44, r_ins(0, 18, 21, 1, 'h00),    32'h1fffe);
    emit(45, r_ins(16, 0, 0, 0, 'h25),     32'd21);
    emit(46, r_ins(17, 0, 0, 0, 'h25),     32'hffffffff);
    emit(47, r_ins(18, 0, 0, 0, 'h25),     32'h0000ffff);
    emit(48, i_ins('h08, 0, 0, 7),         32'd7);
    emit(52, r_ins(0, 0, 0, 0, 'h25),      32'd0);
    emit(53, r_ins(13, 0, 0, 0, 'h25),     32'd1);
    emit(54, r_ins(14, 0, 0, 0, 'h25),     32'd10);
    emit(55, r_ins(15, 0, 0, 0, 'h25),     32'd11);
    emit(56, i_ins('h08, 0, 1, 5),         32'd5);
    emit(57, r_ins(1, 1, 2, 0, 'h20),      32'd0);
    emit(61, r_ins(2, 0, 0, 0, 'h25),      32'd0);
    emit(62, r_ins(1, 1, 0, 0, 'h25),      32'd5);
    do_reset();
    for (int c = 0; c < 67; c++) begin
      e = (c < 3) ? 32'h0 : exp_dir[c-3];
      checks++;
      if (alu_result !== e) begin
        errors++;
        $display("FAIL directed_alu cycle %0d got %h expected %h", c, alu_result, e);
      end
      checks++;
      if (next_instruction !== get_word(c % 64)) begin
        errors++;
        $display("FAIL directed_fetch cycle %0d got %h expected %h", c, next_instruction, get_word(c % 64));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] e;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (alu_result !== 32'h0) begin
      errors++;
      $display("FAIL midreset_alu got %h expected %h", alu_result, 32'h0);
    end
    checks++;
    if (next_instruction !== get_word(0)) begin
      errors++;
      $display("FAIL midreset_fetch got %h expected %h", next_instruction, get_word(0));
    end
    reset = 1'b0;
    model_run(70);
    for (int c = 0; c < 70; c++) begin
      e = (c < 3) ? 32'h0 : m_alu[c-3];
      checks++;
      if (alu_result !== e) begin
        errors++;
        $display("FAIL midreset_rerun cycle %0d got %h expected %h", c, alu_result, e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] e;
    logic [31:0] tbl [0:8];
    tbl = '{32'd5, 32'd0, 32'd0, 32'd0, 32'd10, 32'd0, 32'd0, 32'd0, 32'd0};
    clear_imem();
    put_word(0, i_ins('h08, 0, 1, 5));
    put_word(1, r_ins(1, 1, 2, 0, 'h20));
    put_word(2, r_ins(1, 1, 3, 0, 'h20));
    put_word(3, r_ins(1, 1, 4, 0, 'h20));
    put_word(4, r_ins(1, 1, 5, 0, 'h20));
    do_reset();
    for (int c = 0; c < 12; c++) begin
      e = (c < 3) ? 32'h0 : tbl[c-3];
      checks++;
      if (alu_result !== e) begin
        errors++;
        $display("FAIL back_to_back cycle %0d got %h expected %h", c, alu_result, e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    logic [31:0] e;
    for (int p = 0; p < 3; p++) begin
      for (int s = 0; s < 64; s++) put_word(s, rand_ins());
      model_run(150);
      do_reset();
      for (int c = 0; c < 150; c++) begin
        e = (c < 3) ? 32'h0 : m_alu[c-3];
        checks++;
        if (alu_result !== e) begin
          errors++;
          $display("FAIL random_alu prog %0d cycle %0d got %h expected %h", p, c, alu_result, e);
        end
        checks++;
        if (next_instruction !== get_word(c % 64)) begin
          errors++;
          $display("FAIL random_fetch prog %0d cycle %0d got %h expected %h",
                   p, c, next_instruction, get_word(c % 64));
        end
        @(negedge clk);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
